hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 13 +
 rtl/hazard_ctrl_sat_counter.sv | 20 ++
 rtl/hazard_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU definitions for the hazard controller: FSM encodings and MDU defaults.
// Pure definitions, no logic.
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } hz_state_t;

    localparam int MDU_LATENCY_DEFAULT = 32;
    localparam int CNT_W               = 6;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: counts cycles with inc=1, sticks at all-ones.
// Latency: count updates one cycle after inc; no backpressure.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: MDU stall > branch flush > load-use stall > jump flush.
// Latency: pipeline controls combinational from inputs; MDU occupancy tracked by a 2-state FSM.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = MDU_LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  IF_ID_Rs,
    input  logic [4:0]  IF_ID_Rt,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_RegWrAddr,
    input  logic        EX_BranchTaken,
    input  logic        ID_Jump,
    input  logic        EX_MduStart,
    output logic        PC_Wr,
    output logic        IF_ID_Wr,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Wr,
    output logic        ID_EX_Flush,
    output logic        EX_MEM_Flush,
    output logic        MduBusy,
    output logic        MduDone,
    output logic [31:0] StallCycles
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LATENCY - 1);

    hz_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             done_q;
    logic             mdu_stall;
    logic             load_use;

    // done_q is raised one cycle ahead so it lines up with the cnt==1 cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (EX_MduStart) begin
                        state  <= MDU_WAIT;
                        cnt    <= CNT_INIT;
                        done_q <= (MDU_LATENCY == 2);
                    end else begin
                        done_q <= 1'b0;
                    end
                end
                MDU_WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        state  <= RUN;
                        cnt    <= '0;
                        done_q <= 1'b0;
                    end else begin
                        cnt    <= cnt - 1'b1;
                        done_q <= (cnt == CNT_W'(2));
                    end
                end
                default: begin
                    state  <= RUN;
                    cnt    <= '0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign MduDone   = done_q;
    assign MduBusy   = !rst && ((state == MDU_WAIT) || EX_MduStart);
    assign mdu_stall = MduBusy && !done_q;
    assign load_use  = ID_EX_MemRead && (ID_EX_RegWrAddr != 5'd0) &&
                       ((ID_EX_RegWrAddr == IF_ID_Rs) || (ID_EX_RegWrAddr == IF_ID_Rt));

    always_comb begin
        PC_Wr        = 1'b1;
        IF_ID_Wr     = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Wr     = 1'b1;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        if (!rst) begin
            if (mdu_stall) begin
                PC_Wr        = 1'b0;
                IF_ID_Wr     = 1'b0;
                ID_EX_Wr     = 1'b0;
                EX_MEM_Flush = 1'b1;
            end else if (EX_BranchTaken) begin
                IF_ID_Flush = 1'b1;
                ID_EX_Flush = 1'b1;
            end else if (load_use) begin
                PC_Wr       = 1'b0;
                IF_ID_Wr    = 1'b0;
                ID_EX_Flush = 1'b1;
            end else if (ID_Jump) begin
                IF_ID_Flush = 1'b1;
            end
        end
    end

    sat_counter #(.W(32)) u_stall (
        .clk   (clk),
        .rst   (rst),
        .inc   (!PC_Wr),
        .count (StallCycles)
    );

endmodule
